// File: rtl/clk_rst_gen.sv
// Reset/clock-enable sequencer: lock wait, reset hold, then N_CH free-running CE dividers.
// Latency: LOCKED 2+LOCK_CYCLES edges after RST_N rises, Chip_RST drops HOLD_CYCLES later; no backpressure.
module clk_rst_gen #(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SOFT_RST,
    input  logic [N_CH*DIV_W-1:0] DIV,
    output logic [N_CH-1:0]       CE,
    output logic                  LOCKED,
    output logic                  Chip_RST
);
    localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int PH_W    = $clog2(MAX_CYC + 1);
    localparam logic [PH_W-1:0] LOCK_LAST = PH_W'(LOCK_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_LOCK, ST_HOLD, ST_RUN} state_t;

    logic [1:0]      rst_sync_q;
    logic            rst_sync_n;
    state_t          state_q;
    state_t          state_nxt;
    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_nxt;
    logic            locked_nxt;
    logic            chip_rst_nxt;
    logic            in_run;

    // Assert immediately, release two edges after RST_N rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= ST_LOCK;
            phase_q  <= '0;
            LOCKED   <= 1'b0;
            Chip_RST <= 1'b1;
        end else begin
            state_q  <= state_nxt;
            phase_q  <= phase_nxt;
            LOCKED   <= locked_nxt;
            Chip_RST <= chip_rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_LOCK: if (phase_q == LOCK_LAST) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (SOFT_RST)                    state_nxt = ST_HOLD;
                else if (phase_q == HOLD_LAST)   state_nxt = ST_RUN;
            end
            ST_RUN:  if (SOFT_RST) state_nxt = ST_HOLD;
            default: state_nxt = ST_LOCK;
        endcase
    end

    // Phase counter clears on every state exit so it never wraps; parked at 0 in RUN.
    always_comb begin
        phase_nxt = '0;
        case (state_q)
            ST_LOCK: phase_nxt = (phase_q == LOCK_LAST) ? '0 : phase_q + PH_W'(1);
            ST_HOLD: begin
                if (SOFT_RST || phase_q == HOLD_LAST) phase_nxt = '0;
                else                                  phase_nxt = phase_q + PH_W'(1);
            end
            default: phase_nxt = '0;
        endcase
        locked_nxt   = (state_nxt != ST_LOCK);
        chip_rst_nxt = (state_nxt != ST_RUN);
    end

    assign in_run = (state_q == ST_RUN);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_ch;

        assign div_ch = DIV[g*DIV_W +: DIV_W];
        // Compare with >= so a lowered ratio pulses at once instead of running to overflow.
        assign CE[g]  = in_run && (cnt_q >= div_ch);

        always_ff @(posedge CLK or negedge rst_sync_n) begin
            if (!rst_sync_n) begin
                cnt_q <= '0;
            end else if (in_run && !SOFT_RST) begin
                cnt_q <= CE[g] ? '0 : cnt_q + DIV_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed bench for clk_rst_gen: default instance plus a 4-channel, 1/1-cycle instance.
module tb_clk_rst_gen;
    logic        CLK;
    logic        RST_N;
    logic        soft_a;
    logic        soft_b;
    logic [15:0] div_a;
    logic [31:0] div_b;
    logic [1:0]  ce_a;
    logic [3:0]  ce_b;
    logic        locked_a;
    logic        locked_b;
    logic        chip_rst_a;
    logic        chip_rst_b;

    int n_tests = 0;
    int n_fail  = 0;

    clk_rst_gen dut_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SOFT_RST (soft_a),
        .DIV      (div_a),
        .CE       (ce_a),
        .LOCKED   (locked_a),
        .Chip_RST (chip_rst_a)
    );

    clk_rst_gen #(.N_CH(4), .DIV_W(8), .LOCK_CYCLES(1), .HOLD_CYCLES(1)) dut_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SOFT_RST (soft_b),
        .DIV      (div_b),
        .CE       (ce_b),
        .LOCKED   (locked_b),
        .Chip_RST (chip_rst_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Edge k counted from RST_N release; soft_a pulsed on edge soft_k (lands in LOCK).
    task automatic run_seq(input int kmax, input int soft_k);
        logic [1:0] ea;
        logic [3:0] eb;
        for (int k = 1; k <= kmax; k++) begin
            soft_a = (k == soft_k);
            tick(1);
            ea[1] = (k >= 14);
            ea[0] = (k >= 17) && (((k - 17) % 4) == 0);
            for (int c = 0; c < 4; c++)
                eb[c] = (k >= 4) && (((k - 4) % (c + 1)) == c);
            chk($sformatf("a_locked_e%0d", k), 32'(locked_a),   32'(k >= 10));
            chk($sformatf("a_rst_e%0d", k),    32'(chip_rst_a), 32'(k < 14));
            chk($sformatf("a_ce_e%0d", k),     32'(ce_a),       32'(ea));
            chk($sformatf("b_locked_e%0d", k), 32'(locked_b),   32'(k >= 3));
            chk($sformatf("b_rst_e%0d", k),    32'(chip_rst_b), 32'(k < 4));
            chk($sformatf("b_ce_e%0d", k),     32'(ce_b),       32'(eb));
        end
        soft_a = 1'b0;
    endtask

    initial begin
        int pulses;
        int first;
        int ce1_cnt;
        logic [1:0] ea;

        RST_N  = 1'b0;
        soft_a = 1'b0;
        soft_b = 1'b0;
        div_a  = 16'h0003;
        div_b  = 32'h0302_0100;

        tick(3);
        chk("reset_a_locked", 32'(locked_a),   32'd0);
        chk("reset_a_rst",    32'(chip_rst_a), 32'd1);
        chk("reset_a_ce",     32'(ce_a),       32'd0);
        chk("reset_b_locked", 32'(locked_b),   32'd0);
        chk("reset_b_rst",    32'(chip_rst_b), 32'd1);
        chk("reset_b_ce",     32'(ce_b),       32'd0);

        RST_N = 1'b1;
        run_seq(24, 0);

        // One-cycle soft reset in RUN: 4 hold cycles, CE[0] back 3 cycles after release.
        for (int j = 1; j <= 9; j++) begin
            soft_a = (j == 1);
            tick(1);
            ea[1] = (j >= 5);
            ea[0] = (j >= 5) && (((j - 5) % 4) == 3);
            chk($sformatf("soft_rst_j%0d", j),    32'(chip_rst_a), 32'(j <= 4));
            chk($sformatf("soft_ce_j%0d", j),     32'(ce_a),       32'(ea));
            chk($sformatf("soft_locked_j%0d", j), 32'(locked_a),   32'd1);
        end
        soft_a = 1'b0;

        // Ratio lowered from 7 to 2 while cnt_0 = 5.
        div_a[7:0] = 8'd7;
        soft_a = 1'b1;
        tick(1);
        soft_a = 1'b0;
        tick(4);
        chk("div_run_entry_rst", 32'(chip_rst_a), 32'd0);
        tick(5);
        chk("div_cnt5_ce0", 32'(ce_a[0]), 32'd0);
        div_a[7:0] = 8'd2;
        #1;
        chk("div_change_immediate", 32'(ce_a[0]), 32'd1);
        for (int m = 1; m <= 6; m++) begin
            tick(1);
            chk($sformatf("div2_m%0d", m), 32'(ce_a[0]), 32'((m % 3) == 0));
        end

        // Held soft reset parks in HOLD; then maximum ratio over 1024 cycles.
        div_a[7:0] = 8'd255;
        soft_a = 1'b1;
        for (int h = 1; h <= 6; h++) begin
            tick(1);
            chk($sformatf("soft_held_rst_h%0d", h), 32'(chip_rst_a), 32'd1);
            chk($sformatf("soft_held_ce_h%0d", h),  32'(ce_a),       32'd0);
        end
        soft_a = 1'b0;
        for (int h = 1; h <= 3; h++) begin
            tick(1);
            chk($sformatf("soft_rel_rst_h%0d", h), 32'(chip_rst_a), 32'd1);
        end
        tick(1);
        chk("soft_rel_run", 32'(chip_rst_a), 32'd0);
        pulses  = 0;
        first   = -1;
        ce1_cnt = 0;
        for (int m = 0; m < 1024; m++) begin
            if (m > 0) tick(1);
            if (ce_a[0]) begin
                pulses++;
                if (first < 0) first = m;
            end
            if (ce_a[1]) ce1_cnt++;
        end
        chk("div255_pulses",  32'(pulses),  32'd4);
        chk("div255_first",   32'(first),   32'd255);
        chk("div0_every_cyc", 32'(ce1_cnt), 32'd1024);

        // 3 ns RST_N glitch mid-RUN, then full sequence with a SOFT_RST ignored in LOCK.
        div_a = 16'h0003;
        RST_N = 1'b0;
        #1;
        chk("glitch_a_rst",    32'(chip_rst_a), 32'd1);
        chk("glitch_a_locked", 32'(locked_a),   32'd0);
        chk("glitch_a_ce",     32'(ce_a),       32'd0);
        chk("glitch_b_rst",    32'(chip_rst_b), 32'd1);
        chk("glitch_b_ce",     32'(ce_b),       32'd0);
        #2;
        RST_N = 1'b1;
        run_seq(20, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
